// File: rtl/dcm_clkgen_prog.sv
// dcm_clkgen_prog: serial LoadD/LoadM/GO sequencer for the DCM_CLKGEN
// pixel clock, with PROGDONE/LOCKED supervision and DCM reset on timeout.
module dcm_clkgen_prog #(
  parameter int PROG_DIV   = 2,
  parameter int TIMEOUT    = 65535,
  parameter int RST_CYCLES = 8
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_m,
  input  logic [7:0] cmd_d,
  output logic       prog_clk,
  output logic       prog_en,
  output logic       prog_data,
  input  logic       prog_done,
  input  logic       dcm_locked,
  output logic       dcm_rst,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code
);

  localparam int DW = (PROG_DIV > 1) ? $clog2(PROG_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(PROG_DIV - 1);
  localparam logic [16:0] TMO_MAX = 17'(TIMEOUT - 1);
  localparam logic [16:0] RST_MAX = 17'(RST_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD_D, S_GAP1, S_LOAD_M, S_GAP2,
    S_GO, S_WAIT_DONE, S_WAIT_LOCK, S_RESET_DCM
  } state_t;

  state_t r_state, w_nxt;

  logic [DW-1:0] r_div;
  logic          r_pclk;
  logic          w_fall;
  logic [3:0]    r_cnt, w_cnt;
  logic [9:0]    r_sh, w_sh;
  logic [7:0]    r_m, w_m;
  logic [16:0]   r_tmr, w_tmr;
  logic          r_en, w_en;
  logic          r_data, w_data;
  logic          r_rst;
  logic          r_done, w_done;
  logic          r_err, w_err;
  logic [1:0]    r_code, w_code;
  logic          r_pd1, r_pd2, r_pd3;
  logic          r_lk1, r_lk2;
  logic          w_pd_rise;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_div  <= '0;
      r_pclk <= 1'b0;
    end else if (r_div == DIV_MAX) begin
      r_div  <= '0;
      r_pclk <= ~r_pclk;
    end else begin
      r_div  <= r_div + 1'b1;
    end
  end

  assign w_fall = (r_div == DIV_MAX) && r_pclk;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_pd1 <= 1'b0;
      r_pd2 <= 1'b0;
      r_pd3 <= 1'b0;
      r_lk1 <= 1'b0;
      r_lk2 <= 1'b0;
    end else begin
      r_pd1 <= prog_done;
      r_pd2 <= r_pd1;
      r_pd3 <= r_pd2;
      r_lk1 <= dcm_locked;
      r_lk2 <= r_lk1;
    end
  end

  assign w_pd_rise = r_pd2 & ~r_pd3;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sh    <= '0;
      r_m     <= '0;
      r_tmr   <= '0;
      r_en    <= 1'b0;
      r_data  <= 1'b0;
      r_rst   <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_code  <= 2'b00;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt;
      r_sh    <= w_sh;
      r_m     <= w_m;
      r_tmr   <= w_tmr;
      r_en    <= w_en;
      r_data  <= w_data;
      r_rst   <= (w_nxt == S_RESET_DCM);
      r_done  <= w_done;
      r_err   <= w_err;
      r_code  <= w_code;
    end
  end

  always_comb begin
    w_nxt  = r_state;
    w_cnt  = r_cnt;
    w_sh   = r_sh;
    w_m    = r_m;
    w_tmr  = '0;
    w_en   = r_en;
    w_data = r_data;
    w_done = 1'b0;
    w_err  = r_err;
    w_code = r_code;
    unique case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_nxt  = S_LOAD_D;
          w_cnt  = 4'd10;
          w_sh   = {cmd_d, 2'b01};
          w_m    = cmd_m;
          w_err  = 1'b0;
          w_code = 2'b00;
        end
      end
      S_LOAD_D, S_LOAD_M: begin
        if (w_fall) begin
          w_en   = 1'b1;
          w_data = r_sh[0];
          w_sh   = {1'b0, r_sh[9:1]};
          w_cnt  = r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            w_nxt = (r_state == S_LOAD_D) ? S_GAP1 : S_GAP2;
            w_cnt = 4'd2;
          end
        end
      end
      S_GAP1, S_GAP2: begin
        if (w_fall) begin
          w_en   = 1'b0;
          w_data = 1'b0;
          w_cnt  = r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            if (r_state == S_GAP1) begin
              w_nxt = S_LOAD_M;
              w_cnt = 4'd10;
              w_sh  = {r_m, 2'b11};
            end else begin
              w_nxt = S_GO;
              w_cnt = 4'd1;
            end
          end
        end
      end
      // GO drives one period, then the next fall tick ends it
      S_GO: begin
        if (w_fall) begin
          w_data = 1'b0;
          if (r_cnt != 4'd0) begin
            w_en  = 1'b1;
            w_cnt = 4'd0;
          end else begin
            w_en  = 1'b0;
            w_nxt = S_WAIT_DONE;
          end
        end
      end
      S_WAIT_DONE: begin
        w_tmr = r_tmr + 17'd1;
        if (w_pd_rise) begin
          w_nxt = S_WAIT_LOCK;
          w_tmr = '0;
        end else if (r_tmr == TMO_MAX) begin
          w_nxt  = S_RESET_DCM;
          w_tmr  = '0;
          w_err  = 1'b1;
          w_code = 2'b01;
        end
      end
      S_WAIT_LOCK: begin
        w_tmr = r_tmr + 17'd1;
        if (r_lk2) begin
          w_nxt  = S_IDLE;
          w_done = 1'b1;
        end else if (r_tmr == TMO_MAX) begin
          w_nxt  = S_RESET_DCM;
          w_tmr  = '0;
          w_err  = 1'b1;
          w_code = 2'b10;
        end
      end
      S_RESET_DCM: begin
        w_tmr = r_tmr + 17'd1;
        if (r_tmr == RST_MAX) w_nxt = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign prog_clk  = r_pclk;
  assign prog_en   = r_en;
  assign prog_data = r_data;
  assign dcm_rst   = r_rst;
  assign done      = r_done;
  assign err       = r_err;
  assign err_code  = r_code;

endmodule
